// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with exception redirect, relative jumps, branches,
// and call/return support through a small circular return-address stack.
module pc_sequencer #(
  parameter int            AW           = 32,
  parameter int            STEP         = 1,
  parameter logic [AW-1:0] RESET_VECTOR = '0,
  parameter logic [AW-1:0] EXC_VECTOR   = 'h10,
  parameter int            RAS_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         exc_req,
  input  logic                         jump_en,
  input  logic [AW-1:0]                jump_offset,
  input  logic                         link_en,
  input  logic                         branch_en,
  input  logic                         branch_cond,
  input  logic [AW-1:0]                branch_target,
  input  logic                         ret_en,
  output logic [AW-1:0]                pc,
  output logic                         redirect,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  localparam int            PW     = $clog2(RAS_DEPTH);
  localparam int            CW     = $clog2(RAS_DEPTH + 1);
  localparam logic [AW-1:0] STEP_V = AW'(STEP);
  localparam logic [CW-1:0] FULL   = CW'(RAS_DEPTH);

  logic [AW-1:0] ras [RAS_DEPTH];
  logic [PW-1:0] ptr;

  logic [AW-1:0] pc_next;
  logic [AW-1:0] seq_pc;
  logic          redirect_next;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] top_idx;
  logic [CW-1:0] count_next;
  logic          push;
  logic          overflow_next;
  logic          underflow_next;

  assign seq_pc  = pc + STEP_V;
  assign top_idx = ptr - PW'(1);

  // Next-PC selection by priority; only the winning request may touch the RAS.
  always_comb begin
    pc_next        = seq_pc;
    redirect_next  = 1'b0;
    ptr_next       = ptr;
    count_next     = ras_count;
    push           = 1'b0;
    overflow_next  = 1'b0;
    underflow_next = 1'b0;
    if (exc_req) begin
      pc_next       = EXC_VECTOR;
      redirect_next = 1'b1;
      count_next    = '0;
      ptr_next      = '0;
    end else if (jump_en) begin
      pc_next       = pc + jump_offset;
      redirect_next = 1'b1;
      if (link_en) begin
        // A full stack silently drops its oldest entry, which sits at ptr.
        push     = 1'b1;
        ptr_next = ptr + PW'(1);
        if (ras_count == FULL) begin
          overflow_next = 1'b1;
        end else begin
          count_next = ras_count + CW'(1);
        end
      end
    end else if (branch_en && branch_cond) begin
      pc_next       = branch_target;
      redirect_next = 1'b1;
    end else if (ret_en) begin
      if (ras_count != '0) begin
        pc_next       = ras[top_idx];
        redirect_next = 1'b1;
        ptr_next      = top_idx;
        count_next    = ras_count - CW'(1);
      end else begin
        underflow_next = 1'b1;
      end
    end else if (stall) begin
      pc_next = pc;
    end
  end

  // Architectural state and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_VECTOR;
      redirect      <= 1'b0;
      ptr           <= '0;
      ras_count     <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc            <= pc_next;
      redirect      <= redirect_next;
      ptr           <= ptr_next;
      ras_count     <= count_next;
      ras_overflow  <= overflow_next;
      ras_underflow <= underflow_next;
    end
  end

  // Return-address storage; contents need no reset because ras_count guards reads.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      ras[ptr] <= seq_pc;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a queue-based reference model predicts each
// cycle's outputs, and an independent monitor compares them after every edge.
module tb_pc_sequencer;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h100;
  localparam logic [31:0] EV    = 32'h10;

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        exc;
    logic        jump;
    logic [31:0] off;
    logic        link;
    logic        br;
    logic        cond;
    logic [31:0] tgt;
    logic        ret;
  } stim_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        redirect;
    logic [2:0]  count;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic        clk;
  logic        rst, stall, exc_req, jump_en, link_en, branch_en, branch_cond, ret_en;
  logic [31:0] jump_offset, branch_target;
  logic [31:0] pc;
  logic        redirect;
  logic [2:0]  ras_count;
  logic        ras_overflow, ras_underflow;

  exp_t        expQ[$];
  logic [31:0] modelPc;
  logic [31:0] modelRas[$];
  int          vectors = 0;
  int          miscompares = 0;

  pc_sequencer #(
    .AW(32), .STEP(1), .RESET_VECTOR(RV), .EXC_VECTOR(EV), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .exc_req(exc_req),
    .jump_en(jump_en), .jump_offset(jump_offset), .link_en(link_en),
    .branch_en(branch_en), .branch_cond(branch_cond), .branch_target(branch_target),
    .ret_en(ret_en), .pc(pc), .redirect(redirect), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Reference model: the stack is a plain queue, newest entry at the back.
  function automatic exp_t modelStep(stim_t s);
    exp_t e;
    e = '0;
    if (s.rst) begin
      modelPc = RV;
      modelRas.delete();
    end else if (s.exc) begin
      modelPc = EV;
      modelRas.delete();
      e.redirect = 1'b1;
    end else if (s.jump) begin
      if (s.link) begin
        if (modelRas.size() == DEPTH) begin
          void'(modelRas.pop_front());
          e.ovf = 1'b1;
        end
        modelRas.push_back(modelPc + 32'd1);
      end
      modelPc = modelPc + s.off;
      e.redirect = 1'b1;
    end else if (s.br && s.cond) begin
      modelPc = s.tgt;
      e.redirect = 1'b1;
    end else if (s.ret) begin
      if (modelRas.size() > 0) begin
        modelPc = modelRas.pop_back();
        e.redirect = 1'b1;
      end else begin
        modelPc = modelPc + 32'd1;
        e.unf = 1'b1;
      end
    end else if (!s.stall) begin
      modelPc = modelPc + 32'd1;
    end
    e.pc    = modelPc;
    e.count = 3'(modelRas.size());
    return e;
  endfunction

  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    rst           = s.rst;
    stall         = s.stall;
    exc_req       = s.exc;
    jump_en       = s.jump;
    jump_offset   = s.off;
    link_en       = s.link;
    branch_en     = s.br;
    branch_cond   = s.cond;
    branch_target = s.tgt;
    ret_en        = s.ret;
    expQ.push_back(modelStep(s));
  endtask

  task automatic checkOutput(input exp_t e);
    vectors++;
    if (pc !== e.pc) begin
      miscompares++;
      $display("[TB] FAIL pc at vector %0d: got %h expected %h", vectors, pc, e.pc);
    end
    if (redirect !== e.redirect) begin
      miscompares++;
      $display("[TB] FAIL redirect at vector %0d: got %b expected %b", vectors, redirect, e.redirect);
    end
    if (ras_count !== e.count) begin
      miscompares++;
      $display("[TB] FAIL ras_count at vector %0d: got %0d expected %0d", vectors, ras_count, e.count);
    end
    if (ras_overflow !== e.ovf) begin
      miscompares++;
      $display("[TB] FAIL ras_overflow at vector %0d: got %b expected %b", vectors, ras_overflow, e.ovf);
    end
    if (ras_underflow !== e.unf) begin
      miscompares++;
      $display("[TB] FAIL ras_underflow at vector %0d: got %b expected %b", vectors, ras_underflow, e.unf);
    end
  endtask

  // Monitor: pops one prediction per edge, sampled 1 time unit after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  task automatic goTo(input logic [31:0] target);
    stim_t s;
    s = idle();
    s.br = 1'b1; s.cond = 1'b1; s.tgt = target;
    applyStimulus(s);
  endtask

  task automatic call(input logic [31:0] off);
    stim_t s;
    s = idle();
    s.jump = 1'b1; s.link = 1'b1; s.off = off;
    applyStimulus(s);
  endtask

  task automatic doRet();
    stim_t s;
    s = idle();
    s.ret = 1'b1;
    applyStimulus(s);
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    stim_t s;
    rst = 1'b1; stall = 0; exc_req = 0; jump_en = 0; jump_offset = '0; link_en = 0;
    branch_en = 0; branch_cond = 0; branch_target = '0; ret_en = 0;
    modelPc = '0;

    $display("[TB] reset and sequential advance");
    s = idle(); s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    repeat (5) applyStimulus(idle());

    $display("[TB] stall versus branch");
    s = idle(); s.stall = 1'b1;
    repeat (3) applyStimulus(s);
    s.br = 1'b1; s.cond = 1'b1; s.tgt = 32'h200;
    applyStimulus(s);
    s = idle(); s.br = 1'b1; s.cond = 1'b0; s.tgt = 32'h300;
    applyStimulus(s);

    $display("[TB] call, negative jump, return");
    goTo(32'h10);
    call(32'h30);
    s = idle(); s.jump = 1'b1; s.off = 32'hFFFF_FFF0;
    applyStimulus(s);
    doRet();

    $display("[TB] stack overflow and underflow");
    goTo(32'h0);
    repeat (5) call(32'h100);
    repeat (5) doRet();

    $display("[TB] simultaneous requests");
    call(32'h20);
    call(32'h20);
    s = idle(); s.exc = 1'b1; s.jump = 1'b1; s.off = 32'h8; s.ret = 1'b1;
    applyStimulus(s);
    call(32'h20);
    call(32'h20);
    s = idle(); s.jump = 1'b1; s.off = 32'h40; s.ret = 1'b1;
    applyStimulus(s);
    s = idle(); s.link = 1'b1; s.ret = 1'b0;
    applyStimulus(s);

    $display("[TB] wrap and mid-operation reset");
    goTo(32'hFFFF_FFFF);
    applyStimulus(idle());
    s = idle(); s.rst = 1'b1; s.jump = 1'b1; s.link = 1'b1; s.off = 32'h55;
    applyStimulus(s);
    applyStimulus(idle());

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      s = idle();
      s.rst   = ($urandom_range(0, 99) == 0);
      s.stall = ($urandom_range(0, 3) == 0);
      s.exc   = ($urandom_range(0, 19) == 0);
      s.jump  = ($urandom_range(0, 3) == 0);
      s.link  = ($urandom_range(0, 1) == 1);
      s.off   = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 64)) - 32'd32;
      s.br    = ($urandom_range(0, 4) == 0);
      s.cond  = ($urandom_range(0, 1) == 1);
      s.tgt   = $urandom();
      s.ret   = ($urandom_range(0, 2) == 0);
      applyStimulus(s);
    end

    @(negedge clk);
    @(negedge clk);
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
